// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter giving requesters A and B one shared register-bank port, one outstanding read.
// Define REG_ARB_TIMEOUT_EN to add a read-return timeout (error return after TIMEOUT wait cycles).
module reg_bank_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESETN,
  input  logic                    a_wr_en,
  input  logic [ADDR_WIDTH-1:0]   a_wr_addr,
  input  logic [DATA_WIDTH-1:0]   a_wr_data,
  input  logic [DATA_WIDTH/8-1:0] a_wr_strb,
  input  logic                    a_rd_en,
  input  logic [ADDR_WIDTH-1:0]   a_rd_addr,
  output logic [DATA_WIDTH-1:0]   a_rd_data,
  output logic                    a_rd_valid,
  output logic                    a_rd_err,
  output logic                    a_wr_pend,
  output logic                    a_rd_pend,
  output logic                    a_ovf,
  input  logic                    b_wr_en,
  input  logic [ADDR_WIDTH-1:0]   b_wr_addr,
  input  logic [DATA_WIDTH-1:0]   b_wr_data,
  input  logic [DATA_WIDTH/8-1:0] b_wr_strb,
  input  logic                    b_rd_en,
  input  logic [ADDR_WIDTH-1:0]   b_rd_addr,
  output logic [DATA_WIDTH-1:0]   b_rd_data,
  output logic                    b_rd_valid,
  output logic                    b_rd_err,
  output logic                    b_wr_pend,
  output logic                    b_rd_pend,
  output logic                    b_ovf,
  output logic                    m_wr_en,
  output logic [ADDR_WIDTH-1:0]   m_wr_addr,
  output logic [DATA_WIDTH-1:0]   m_wr_data,
  output logic [DATA_WIDTH/8-1:0] m_wr_strb,
  output logic                    m_rd_en,
  output logic [ADDR_WIDTH-1:0]   m_rd_addr,
  input  logic [DATA_WIDTH-1:0]   m_rd_data,
  input  logic                    m_rd_valid
);

  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic {R_IDLE, R_WAIT} rd_state_t;

  // Index 0 is requester A, index 1 is requester B; pointer value 1 means B was granted last.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_b);
    logic [1:0] gnt;
    gnt = req;
    if (req == 2'b11) gnt = last_b ? 2'b01 : 2'b10;
    return gnt;
  endfunction

  logic [1:0]                 wr_req, rd_req;
  logic [1:0][ADDR_WIDTH-1:0] wr_addr_in, rd_addr_in;
  logic [1:0][DATA_WIDTH-1:0] wr_data_in;
  logic [1:0][SW-1:0]         wr_strb_in;

  assign wr_req     = {b_wr_en, a_wr_en};
  assign rd_req     = {b_rd_en, a_rd_en};
  assign wr_addr_in = {b_wr_addr, a_wr_addr};
  assign rd_addr_in = {b_rd_addr, a_rd_addr};
  assign wr_data_in = {b_wr_data, a_wr_data};
  assign wr_strb_in = {b_wr_strb, a_wr_strb};

  logic [1:0]                 wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
  logic [1:0][ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [1:0][DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [1:0][SW-1:0]         wr_strb_q, wr_strb_d;
  logic [1:0]                 ovf_q, ovf_d;
  logic                       wr_last_q, wr_last_d, rd_last_q, rd_last_d;
  logic                       m_wr_en_q, m_wr_en_d, m_rd_en_q, m_rd_en_d;
  logic [ADDR_WIDTH-1:0]      m_wr_addr_q, m_wr_addr_d, m_rd_addr_q, m_rd_addr_d;
  logic [DATA_WIDTH-1:0]      m_wr_data_q, m_wr_data_d;
  logic [SW-1:0]              m_wr_strb_q, m_wr_strb_d;
  rd_state_t                  rd_state_q, rd_state_d;
  logic                       rd_owner_q, rd_owner_d;
  logic [1:0]                 rd_vld_q, rd_vld_d;
  logic [1:0][DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic [1:0] wr_gnt, rd_gnt, rd_hazard, rd_elig;
  logic       rd_free, rd_timeout;

  // A read may not pass a write to the same address that is still queued or leaving this cycle.
  always_comb begin
    rd_hazard = '0;
    for (int i = 0; i < 2; i++) begin
      if (m_wr_en_q && (m_wr_addr_q == rd_addr_q[i])) rd_hazard[i] = 1'b1;
      for (int j = 0; j < 2; j++) begin
        if (wr_pend_q[j] && (wr_addr_q[j] == rd_addr_q[i])) rd_hazard[i] = 1'b1;
      end
    end
  end

  assign rd_elig = rd_pend_q & ~rd_hazard;
  // The cycle that completes a read may already launch the next one.
  assign rd_free = (rd_state_q == R_IDLE) || m_rd_valid || rd_timeout;
  assign wr_gnt  = rr_pick(wr_pend_q, wr_last_q);
  assign rd_gnt  = rd_free ? rr_pick(rd_elig, rd_last_q) : 2'b00;

  always_comb begin
    wr_pend_d   = wr_pend_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_strb_d   = wr_strb_q;
    rd_pend_d   = rd_pend_q;
    rd_addr_d   = rd_addr_q;
    ovf_d       = ovf_q;
    wr_last_d   = wr_last_q;
    rd_last_d   = rd_last_q;
    m_wr_en_d   = 1'b0;
    m_wr_addr_d = m_wr_addr_q;
    m_wr_data_d = m_wr_data_q;
    m_wr_strb_d = m_wr_strb_q;
    m_rd_en_d   = 1'b0;
    m_rd_addr_d = m_rd_addr_q;
    rd_state_d  = rd_state_q;
    rd_owner_d  = rd_owner_q;
    rd_vld_d    = '0;
    rd_data_d   = rd_data_q;

    for (int i = 0; i < 2; i++) begin
      if (wr_gnt[i]) wr_pend_d[i] = 1'b0;
      if (wr_req[i]) begin
        if (!wr_pend_q[i] || wr_gnt[i]) begin
          wr_pend_d[i] = 1'b1;
          wr_addr_d[i] = wr_addr_in[i];
          wr_data_d[i] = wr_data_in[i];
          wr_strb_d[i] = wr_strb_in[i];
        end else begin
          ovf_d[i] = 1'b1;
        end
      end
      if (rd_gnt[i]) rd_pend_d[i] = 1'b0;
      if (rd_req[i]) begin
        if (!rd_pend_q[i] || rd_gnt[i]) begin
          rd_pend_d[i] = 1'b1;
          rd_addr_d[i] = rd_addr_in[i];
        end else begin
          ovf_d[i] = 1'b1;
        end
      end
    end

    if (|wr_gnt) begin
      m_wr_en_d   = 1'b1;
      m_wr_addr_d = wr_addr_q[wr_gnt[1]];
      m_wr_data_d = wr_data_q[wr_gnt[1]];
      m_wr_strb_d = wr_strb_q[wr_gnt[1]];
      wr_last_d   = wr_gnt[1];
    end

    case (rd_state_q)
      R_WAIT: begin
        if (m_rd_valid) begin
          rd_vld_d[rd_owner_q]  = 1'b1;
          rd_data_d[rd_owner_q] = m_rd_data;
          rd_state_d            = R_IDLE;
        end else if (rd_timeout) begin
          rd_vld_d[rd_owner_q]  = 1'b1;
          rd_data_d[rd_owner_q] = '0;
          rd_state_d            = R_IDLE;
        end
      end
      default: rd_state_d = rd_state_q;
    endcase

    if (|rd_gnt) begin
      m_rd_en_d   = 1'b1;
      m_rd_addr_d = rd_addr_q[rd_gnt[1]];
      rd_owner_d  = rd_gnt[1];
      rd_last_d   = rd_gnt[1];
      rd_state_d  = R_WAIT;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_pend_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_strb_q   <= '0;
      rd_pend_q   <= '0;
      rd_addr_q   <= '0;
      ovf_q       <= '0;
      wr_last_q   <= 1'b1;
      rd_last_q   <= 1'b1;
      m_wr_en_q   <= 1'b0;
      m_wr_addr_q <= '0;
      m_wr_data_q <= '0;
      m_wr_strb_q <= '0;
      m_rd_en_q   <= 1'b0;
      m_rd_addr_q <= '0;
      rd_state_q  <= R_IDLE;
      rd_owner_q  <= 1'b0;
      rd_vld_q    <= '0;
      rd_data_q   <= '0;
    end else begin
      wr_pend_q   <= wr_pend_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_strb_q   <= wr_strb_d;
      rd_pend_q   <= rd_pend_d;
      rd_addr_q   <= rd_addr_d;
      ovf_q       <= ovf_d;
      wr_last_q   <= wr_last_d;
      rd_last_q   <= rd_last_d;
      m_wr_en_q   <= m_wr_en_d;
      m_wr_addr_q <= m_wr_addr_d;
      m_wr_data_q <= m_wr_data_d;
      m_wr_strb_q <= m_wr_strb_d;
      m_rd_en_q   <= m_rd_en_d;
      m_rd_addr_q <= m_rd_addr_d;
      rd_state_q  <= rd_state_d;
      rd_owner_q  <= rd_owner_d;
      rd_vld_q    <= rd_vld_d;
      rd_data_q   <= rd_data_d;
    end
  end

`ifdef REG_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic [1:0]       rd_err_q, rd_err_d;

  // A bank return in the timeout cycle takes priority over the error return.
  assign rd_timeout = (rd_state_q == R_WAIT) && (to_cnt_q == CNT_W'(TIMEOUT));

  always_comb begin
    to_cnt_d = to_cnt_q;
    rd_err_d = '0;
    if (|rd_gnt) to_cnt_d = '0;
    else if ((rd_state_q == R_WAIT) && !rd_timeout) to_cnt_d = to_cnt_q + CNT_W'(1);
    if (rd_timeout && !m_rd_valid) rd_err_d[rd_owner_q] = 1'b1;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      to_cnt_q <= '0;
      rd_err_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
      rd_err_q <= rd_err_d;
    end
  end

  assign a_rd_err = rd_err_q[0];
  assign b_rd_err = rd_err_q[1];
`else
  assign rd_timeout = 1'b0;
  assign a_rd_err   = 1'b0;
  assign b_rd_err   = 1'b0;
`endif

  assign a_wr_pend  = wr_pend_q[0];
  assign b_wr_pend  = wr_pend_q[1];
  assign a_rd_pend  = rd_pend_q[0];
  assign b_rd_pend  = rd_pend_q[1];
  assign a_ovf      = ovf_q[0];
  assign b_ovf      = ovf_q[1];
  assign a_rd_valid = rd_vld_q[0];
  assign b_rd_valid = rd_vld_q[1];
  assign a_rd_data  = rd_data_q[0];
  assign b_rd_data  = rd_data_q[1];
  assign m_wr_en    = m_wr_en_q;
  assign m_wr_addr  = m_wr_addr_q;
  assign m_wr_data  = m_wr_data_q;
  assign m_wr_strb  = m_wr_strb_q;
  assign m_rd_en    = m_rd_en_q;
  assign m_rd_addr  = m_rd_addr_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Scoreboard bench for reg_bank_arbiter: expected bank writes and read returns are queued at
// stimulus time and compared when the DUT produces them; a small bank model answers reads.
module tb_reg_bank_arbiter;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } rd_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_wr_en, a_rd_en, b_wr_en, b_rd_en;
  logic [3:0]  a_wr_addr, a_rd_addr, b_wr_addr, b_rd_addr;
  logic [31:0] a_wr_data, b_wr_data;
  logic [3:0]  a_wr_strb, b_wr_strb;
  logic [31:0] a_rd_data, b_rd_data;
  logic        a_rd_valid, a_rd_err, a_wr_pend, a_rd_pend, a_ovf;
  logic        b_rd_valid, b_rd_err, b_wr_pend, b_rd_pend, b_ovf;
  logic        m_wr_en, m_rd_en, m_rd_valid;
  logic [3:0]  m_wr_addr, m_wr_strb, m_rd_addr;
  logic [31:0] m_wr_data, m_rd_data;

  always #5 clk = ~clk;

  reg_bank_arbiter dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .a_wr_en(a_wr_en), .a_wr_addr(a_wr_addr), .a_wr_data(a_wr_data), .a_wr_strb(a_wr_strb),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data), .a_rd_valid(a_rd_valid),
    .a_rd_err(a_rd_err), .a_wr_pend(a_wr_pend), .a_rd_pend(a_rd_pend), .a_ovf(a_ovf),
    .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data), .b_wr_strb(b_wr_strb),
    .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data), .b_rd_valid(b_rd_valid),
    .b_rd_err(b_rd_err), .b_wr_pend(b_wr_pend), .b_rd_pend(b_rd_pend), .b_ovf(b_ovf),
    .m_wr_en(m_wr_en), .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data), .m_wr_strb(m_wr_strb),
    .m_rd_en(m_rd_en), .m_rd_addr(m_rd_addr), .m_rd_data(m_rd_data), .m_rd_valid(m_rd_valid)
  );

  int  n_vec = 0;
  int  n_bad = 0;
  int  cyc = 0;
  int  bank_due = -1;
  int  b_ret_n = 0;
  logic [3:0]  bank_addr = 4'h0;
  logic        bank_silent = 1'b0;
  logic        late_kick = 1'b0;
  logic [31:0] mem [16];
  wr_t exp_wr[$];
  rd_t exp_a[$];
  rd_t exp_b[$];
  int  wr_q[$];
  int  rd_q[$];
  int  vld_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Bank model: answers each read three cycles after m_rd_en, unless silenced.
  always @(posedge clk) begin
    #2;
    if (late_kick || (!bank_silent && cyc == bank_due)) begin
      m_rd_valid = 1'b1;
      m_rd_data  = mem[bank_addr];
    end else begin
      m_rd_valid = 1'b0;
      m_rd_data  = '0;
    end
  end

  always @(negedge clk) begin
    if (m_wr_en) begin
      wr_q.push_back(cyc);
      for (int k = 0; k < 4; k++)
        if (m_wr_strb[k]) mem[m_wr_addr][8*k +: 8] = m_wr_data[8*k +: 8];
      if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
      else begin
        wr_t e;
        e = exp_wr.pop_front();
        chk("wr_addr", {28'h0, m_wr_addr}, {28'h0, e.addr});
        chk("wr_data", m_wr_data, e.data);
        chk("wr_strb", {28'h0, m_wr_strb}, {28'h0, e.strb});
      end
    end
    if (a_rd_valid) begin
      if (exp_a.size() == 0) chk("a_ret_unexpected", 1, 0);
      else begin
        rd_t e;
        e = exp_a.pop_front();
        chk("a_ret_data", a_rd_data, e.data);
        chk("a_ret_err", {31'h0, a_rd_err}, {31'h0, e.err});
        if (!e.err) chk("a_ret_lat", cyc, (vld_q.size() > 0) ? vld_q[$] + 1 : -1);
      end
    end
    if (b_rd_valid) begin
      b_ret_n++;
      if (exp_b.size() == 0) chk("b_ret_unexpected", 1, 0);
      else begin
        rd_t e;
        e = exp_b.pop_front();
        chk("b_ret_data", b_rd_data, e.data);
        chk("b_ret_err", {31'h0, b_rd_err}, {31'h0, e.err});
        if (!e.err) chk("b_ret_lat", cyc, (vld_q.size() > 0) ? vld_q[$] + 1 : -1);
      end
    end
    if (m_rd_en) begin
      rd_q.push_back(cyc);
      bank_addr = m_rd_addr;
      bank_due  = cyc + 3;
    end
    if (m_rd_valid) vld_q.push_back(cyc);
  end

  task automatic step();
    @(posedge clk);
    #1;
    a_wr_en = 1'b0; b_wr_en = 1'b0; a_rd_en = 1'b0; b_rd_en = 1'b0;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((exp_wr.size() + exp_a.size() + exp_b.size()) != 0 && n < max) begin
      step();
      n++;
    end
    chk("drain_left", exp_wr.size() + exp_a.size() + exp_b.size(), 0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_a_rd_data", a_rd_data, 0);   chk("rst_b_rd_data", b_rd_data, 0);
    chk("rst_a_rd_valid", {31'h0, a_rd_valid}, 0); chk("rst_b_rd_valid", {31'h0, b_rd_valid}, 0);
    chk("rst_a_rd_err", {31'h0, a_rd_err}, 0);     chk("rst_b_rd_err", {31'h0, b_rd_err}, 0);
    chk("rst_a_wr_pend", {31'h0, a_wr_pend}, 0);   chk("rst_b_wr_pend", {31'h0, b_wr_pend}, 0);
    chk("rst_a_rd_pend", {31'h0, a_rd_pend}, 0);   chk("rst_b_rd_pend", {31'h0, b_rd_pend}, 0);
    chk("rst_a_ovf", {31'h0, a_ovf}, 0);           chk("rst_b_ovf", {31'h0, b_ovf}, 0);
    chk("rst_m_wr_en", {31'h0, m_wr_en}, 0);       chk("rst_m_rd_en", {31'h0, m_rd_en}, 0);
    chk("rst_m_wr_addr", {28'h0, m_wr_addr}, 0);   chk("rst_m_wr_data", m_wr_data, 0);
    chk("rst_m_wr_strb", {28'h0, m_wr_strb}, 0);   chk("rst_m_rd_addr", {28'h0, m_rd_addr}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int nret;
    for (int i = 0; i < 16; i++) mem[i] = 32'hA5A5_0000 | i;
    a_wr_en = 0; b_wr_en = 0; a_rd_en = 0; b_rd_en = 0;
    a_wr_addr = 0; b_wr_addr = 0; a_rd_addr = 0; b_rd_addr = 0;
    a_wr_data = 0; b_wr_data = 0; a_wr_strb = 0; b_wr_strb = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();

    // Two simultaneous write pairs: A wins the first tie after reset, and again after B was last.
    c0 = cyc; wr_q.delete();
    a_wr_en = 1; a_wr_addr = 4'h0; a_wr_data = 32'h1111_0000; a_wr_strb = 4'hF;
    b_wr_en = 1; b_wr_addr = 4'h8; b_wr_data = 32'h2222_0000; b_wr_strb = 4'hF;
    exp_wr.push_back('{4'h0, 32'h1111_0000, 4'hF});
    exp_wr.push_back('{4'h8, 32'h2222_0000, 4'hF});
    step();
    repeat (3) step();
    a_wr_en = 1; a_wr_addr = 4'h0; a_wr_data = 32'h3333_0000; a_wr_strb = 4'hF;
    b_wr_en = 1; b_wr_addr = 4'h8; b_wr_data = 32'h4444_0000; b_wr_strb = 4'h3;
    exp_wr.push_back('{4'h0, 32'h3333_0000, 4'hF});
    exp_wr.push_back('{4'h8, 32'h4444_0000, 4'h3});
    step();
    drain(20);
    chk("tie1_first_cyc", wr_q[0] - c0, 2);
    chk("tie1_second_cyc", wr_q[1] - c0, 3);
    chk("tie2_first_cyc", wr_q[2] - c0, 6);
    chk("tie2_second_cyc", wr_q[3] - c0, 7);

    // Single uncontended write: pending for one cycle, issued two cycles after the request.
    c0 = cyc; wr_q.delete();
    a_wr_en = 1; a_wr_addr = 4'h4; a_wr_data = 32'h1234_5678; a_wr_strb = 4'hF;
    exp_wr.push_back('{4'h4, 32'h1234_5678, 4'hF});
    step();
    @(negedge clk);
    chk("w1_pend_c1", {31'h0, a_wr_pend}, 1);
    chk("w1_men_c1", {31'h0, m_wr_en}, 0);
    @(negedge clk);
    chk("w1_pend_c2", {31'h0, a_wr_pend}, 0);
    chk("w1_men_c2", {31'h0, m_wr_en}, 1);
    @(posedge clk); #1;
    drain(10);

    // Read-after-write to the same address: read must reach the bank after the write.
    wr_q.delete(); rd_q.delete(); vld_q.delete();
    b_wr_en = 1; b_wr_addr = 4'hC; b_wr_data = 32'hCAFE_F00D; b_wr_strb = 4'hF;
    a_rd_en = 1; a_rd_addr = 4'hC;
    exp_wr.push_back('{4'hC, 32'hCAFE_F00D, 4'hF});
    exp_a.push_back('{32'hCAFE_F00D, 1'b0});
    step();
    drain(40);
    chk("raw_order", {31'h0, (rd_q.size() > 0 && wr_q.size() > 0 && rd_q[0] > wr_q[0])}, 1);

    // Overflow: A re-requests while its slot is full and B holds the write grant.
    c0 = cyc;
    a_wr_en = 1; a_wr_addr = 4'h1; a_wr_data = 32'hAAAA_0001; a_wr_strb = 4'hF;
    b_wr_en = 1; b_wr_addr = 4'h2; b_wr_data = 32'hBBBB_0002; b_wr_strb = 4'hF;
    exp_wr.push_back('{4'h1, 32'hAAAA_0001, 4'hF});
    exp_wr.push_back('{4'h2, 32'hBBBB_0002, 4'hF});
    step();
    a_wr_en = 1; a_wr_addr = 4'h3; a_wr_data = 32'hAAAA_0003; a_wr_strb = 4'hF;
    exp_wr.push_back('{4'h3, 32'hAAAA_0003, 4'hF});
    step();
    a_wr_en = 1; a_wr_addr = 4'h5; a_wr_data = 32'hDEAD_DEAD; a_wr_strb = 4'hF;
    @(negedge clk);
    chk("ovf_before_drop", {31'h0, a_ovf}, 0);
    chk("ovf_slot_full", {31'h0, a_wr_pend}, 1);
    step();
    @(negedge clk);
    chk("ovf_after_drop", {31'h0, a_ovf}, 1);
    chk("ovf_b_clear", {31'h0, b_ovf}, 0);
    @(posedge clk); #1;
    drain(20);
    repeat (5) step();
    chk("ovf_sticky", {31'h0, a_ovf}, 1);

    // Read with a silent bank.
    bank_silent = 1'b1;
    nret = b_ret_n;
    b_rd_en = 1; b_rd_addr = 4'h2;
`ifdef REG_ARB_TIMEOUT_EN
    exp_b.push_back('{32'h0, 1'b1});
`endif
    step();
    repeat (40) step();
`ifdef REG_ARB_TIMEOUT_EN
    chk("timeout_returned", exp_b.size(), 0);
    late_kick = 1'b1;
    step();
    late_kick = 1'b0;
    repeat (3) step();
    chk("late_valid_ignored", b_ret_n - nret, 1);
`else
    chk("no_return_without_timeout", b_ret_n - nret, 0);
`endif

    // Both read slots occupied while a bank read is outstanding, then an asynchronous reset.
    a_rd_en = 1; a_rd_addr = 4'h1;
    step();
    repeat (3) step();
    a_rd_en = 1; a_rd_addr = 4'h5; b_rd_en = 1; b_rd_addr = 4'h7;
    step();
    step();
    @(negedge clk);
    chk("pre_rst_a_rd_pend", {31'h0, a_rd_pend}, 1);
    chk("pre_rst_b_rd_pend", {31'h0, b_rd_pend}, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    bank_due = -1;
    @(negedge clk);
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bank_silent = 1'b0;
    step();

    // First ties after reset go to A on both channels; next read launches the cycle after a return.
    c0 = cyc; wr_q.delete(); rd_q.delete(); vld_q.delete();
    a_wr_en = 1; a_wr_addr = 4'h9; a_wr_data = 32'h9999_0009; a_wr_strb = 4'hF;
    b_wr_en = 1; b_wr_addr = 4'hA; b_wr_data = 32'hBBBB_000A; b_wr_strb = 4'hC;
    a_rd_en = 1; a_rd_addr = 4'h5;
    b_rd_en = 1; b_rd_addr = 4'h6;
    exp_wr.push_back('{4'h9, 32'h9999_0009, 4'hF});
    exp_wr.push_back('{4'hA, 32'hBBBB_000A, 4'hC});
    exp_a.push_back('{mem[5], 1'b0});
    exp_b.push_back('{mem[6], 1'b0});
    step();
    drain(40);
    chk("post_rst_wr_cyc", wr_q[0] - c0, 2);
    chk("post_rst_rd_cyc", rd_q[0] - c0, 2);
    chk("rd_back_to_back", rd_q[1], vld_q[0] + 1);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_bank_arbiter.md
# reg_bank_arbiter

Shares one register-bank access port between two requesters: requester A (AXI4-Lite slave side) and requester B (PL fabric master, e.g. a local sequencer). Both issue single-cycle write and read pulses with no backpressure. The block buffers one write and one read per requester, arbitrates each channel round-robin, and keeps at most one bank read outstanding. It routes each read return to the requester that issued it, and sits between the AXI4-Lite interface and the register bank.

## Interface
- ADDR_WIDTH, 4, register address width
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
- TIMEOUT, 15, read-return timeout in cycles (used only with REG_ARB_TIMEOUT_EN)

- S_AXI_ACLK  in  1  clock; all logic is rising-edge
- S_AXI_ARESETN  in  1  asynchronous active-low reset
- x_wr_en  in  1  write request pulse (x = a, b; same port set per requester)
- x_wr_addr / x_wr_data / x_wr_strb  in  ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8  write payload, sampled with x_wr_en
- x_rd_en  in  1  read request pulse
- x_rd_addr  in  ADDR_WIDTH  read address, sampled with x_rd_en
- x_rd_data  out  DATA_WIDTH  read return data
- x_rd_valid  out  1  one-cycle read return pulse
- x_rd_err  out  1  qualifies x_rd_valid: timeout return
- x_wr_pend / x_rd_pend  out  1  slot occupied
- x_ovf  out  1  sticky: a request was dropped
- m_wr_en  out  1  bank write pulse
- m_wr_addr / m_wr_data / m_wr_strb  out  bank write payload
- m_rd_en  out  1  bank read pulse
- m_rd_addr  out  ADDR_WIDTH  bank read address
- m_rd_data  in  DATA_WIDTH  bank read data
- m_rd_valid  in  1  bank read data valid

## Operation
- Slots: each requester has a write slot (addr, data, strb) and a read slot (addr). x_wr_en loads the write slot; x_rd_en loads the read slot.
- Full-slot requests: a request to a full slot that is not being granted in the same cycle is dropped and sets x_ovf. A request arriving in the cycle its slot is granted is accepted and reloads the slot.
- Write channel: one grant per cycle.
  - If only one slot is pending, grant it.
  - If both are pending, grant the requester not granted most recently. The last-grant pointer resets to B, so A wins the first tie.
  - The grant registers m_wr_* with m_wr_en=1 for one cycle and clears the slot.
- Read FSM, R_IDLE:
  - Grant a pending read slot using the same round-robin rule with a separate pointer.
  - Register m_rd_en=1 and m_rd_addr, record the owner, clear the slot, go to R_WAIT.
- Read-after-write guard: a read slot whose address matches any pending write slot, or the m_wr_addr being issued this cycle, is not eligible. This guarantees reads observe earlier-accepted writes.
- Read FSM, R_WAIT:
  - On m_rd_valid, register the owner's x_rd_data = m_rd_data and pulse x_rd_valid, with x_rd_err=0. Return to R_IDLE.
  - No new bank read is issued while in R_WAIT.
- m_rd_valid in R_IDLE is ignored.
- Write and read channels operate independently and may issue in the same cycle.
- Reset, including mid-operation: all slots, pointers, FSM and flags are cleared, and any outstanding read is abandoned.
  - Zero after reset: every output, including x_rd_data, m_wr_*, m_rd_addr and x_ovf.
  - Pointers return to B.

## Timing
- Uncontended write: x_wr_en in cycle N, m_wr_en in cycle N+2. Losing arbitration adds 1 cycle. Worst case is N+3.
- Uncontended read: x_rd_en in cycle N, m_rd_en in cycle N+2. A blocked read adds 1 cycle per blocking cycle (outstanding read or address guard).
- Return: m_rd_valid in cycle M, x_rd_valid/x_rd_data in cycle M+1. The earliest next m_rd_en is M+1.
- x_wr_pend / x_rd_pend are high from the cycle after load through the cycle of grant.
- x_ovf sets in the cycle after the drop.

## Configuration
- REG_ARB_TIMEOUT_EN defined:
  - A $clog2(TIMEOUT+1)-bit counter clears on entry to R_WAIT and increments each R_WAIT cycle.
  - If m_rd_valid has not arrived when the counter reaches TIMEOUT, pulse the owner's x_rd_valid with x_rd_data=0 and x_rd_err=1, then go to R_IDLE.
  - m_rd_valid arriving in the same cycle as the timeout wins: normal return.
- REG_ARB_TIMEOUT_EN undefined: R_WAIT waits indefinitely, x_rd_err is tied 0, and there is no counter.

## Test plan
- A write addr 0x4, data 0x12345678, strb 0xF in cycle 0 -> m_wr_en in cycle 2 with matching payload; a_wr_pend high in cycle 1 only.
- A and B writes (0x0 and 0x8) in the same cycle, twice -> first pair issues A then B; second pair issues A then B again (pointer alternates); one m_wr_en per cycle.
- B write 0xC=0xCAFEF00D and A read 0xC in the same cycle -> m_rd_en follows m_wr_en; bank returns 0xCAFEF00D after 3 cycles -> a_rd_valid 1 cycle later with that data; b_rd_valid stays 0.
- Second a_wr_en while a_wr_pend is high and B holds the grant -> request dropped, a_ovf=1 and remaining 1 until reset.
- With REG_ARB_TIMEOUT_EN and TIMEOUT=15, B read with bank silent -> b_rd_valid with b_rd_err=1 and data 0 after 15 R_WAIT cycles; late m_rd_valid ignored; without the macro, no return.
- Assert reset during R_WAIT with both slots full -> all outputs 0; first post-reset tie grants A.
